// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, sequencer state encoding and
// the opcode field width used by the program sequencer and its decoder.
package cpu_pkg;

    localparam int OPCODE_WIDTH = 4;

    // Instruction opcodes carried in instruction[3:0]; 1000-1110 are undefined.
    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOT   = 4'b0101,
        OP_LOAD  = 4'b0110,
        OP_STORE = 4'b0111,
        OP_NOP   = 4'b1111
    } opcode_e;

    // Fetch/decode/execute controller states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM
    } seq_state_e;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier for the program sequencer. Exactly one of
// is_alu / is_mem / is_nop / is_illegal is set for any input value.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    is_alu,
    output logic                    is_mem,
    output logic                    is_store,
    output logic                    is_nop,
    output logic                    is_illegal
);

    // Classify the opcode into its instruction class.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        is_alu     = 1'b0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_nop     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: is_alu = 1'b1;
            OP_LOAD:  is_mem = 1'b1;
            OP_STORE: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_NOP:   is_nop = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the instruction ROM.
// Owns the PC, latches each instruction, issues one-cycle ALU strobes and
// held load/store requests, and counts retired instructions (saturating).
// Optional build macro PROGRAM_SEQUENCER_STEP_EN adds a 'step' input that
// gates each FETCH, giving single-instruction stepping.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int BITS_FOR_INSTRUCTIONS  = 5,
    parameter int INSTRUCTION_WIDTH      = 16,
    parameter int NUMBER_OF_INSTRUCTIONS = 32,
    parameter int HALT_ON_WRAP           = 1,
    parameter int COUNT_WIDTH            = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      run,
`ifdef PROGRAM_SEQUENCER_STEP_EN
    input  logic                                      step,
`endif
    output logic [BITS_FOR_INSTRUCTIONS-1:0]          instruction_address,
    input  logic [INSTRUCTION_WIDTH-1:0]              instruction,
    output logic [OPCODE_WIDTH-1:0]                   alu_op,
    output logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic                                      alu_en,
    output logic                                      mem_req,
    output logic                                      mem_we,
    input  logic                                      mem_ack,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      illegal,
    output logic [COUNT_WIDTH-1:0]                    retired_count
);

    localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_PC =
        BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);

    seq_state_e                                state_q, state_d;
    logic [BITS_FOR_INSTRUCTIONS-1:0]          pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0]              ir_q, ir_d;
    logic [OPCODE_WIDTH-1:0]                   alu_op_q, alu_op_d;
    logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0] operand_q, operand_d;
    logic                                      alu_en_q, alu_en_d;
    logic                                      mem_req_q, mem_req_d;
    logic                                      mem_we_q, mem_we_d;
    logic                                      done_q, done_d;
    logic                                      illegal_q, illegal_d;
    logic [COUNT_WIDTH-1:0]                    retired_count_q, retired_count_d;

    logic fetch_go;
    logic retire;
    logic dec_is_alu, dec_is_mem, dec_is_store, dec_is_nop, dec_is_illegal;

`ifdef PROGRAM_SEQUENCER_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    opcode_decoder u_decoder (
        .opcode     (ir_q[OPCODE_WIDTH-1:0]),
        .is_alu     (dec_is_alu),
        .is_mem     (dec_is_mem),
        .is_store   (dec_is_store),
        .is_nop     (dec_is_nop),
        .is_illegal (dec_is_illegal)
    );

    // Next-state and next-output logic; retire is folded in after the case.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ir_d            = ir_q;
        alu_op_d        = alu_op_q;
        operand_d       = operand_q;
        alu_en_d        = 1'b0;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        done_d          = 1'b0;
        illegal_d       = illegal_q;
        retired_count_d = retired_count_q;
        retire          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // Pausing here keeps the PC so run=1 resumes at the same address.
                if (!run) begin
                    state_d = S_IDLE;
                end else if (fetch_go) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_op_d  = ir_q[OPCODE_WIDTH-1:0];
                operand_d = ir_q[INSTRUCTION_WIDTH-1:OPCODE_WIDTH];
                if (dec_is_alu) begin
                    alu_en_d = 1'b1;
                    state_d  = S_EXEC;
                end else if (dec_is_mem) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = dec_is_store;
                    state_d   = S_MEM;
                end else if (dec_is_nop || dec_is_illegal) begin
                    // An undefined opcode flags illegal and otherwise behaves as NOP.
                    illegal_d = illegal_q | dec_is_illegal;
                    retire    = 1'b1;
                end
            end
            S_EXEC: begin
                retire = 1'b1;
            end
            S_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    retire    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            if (retired_count_q != {COUNT_WIDTH{1'b1}}) begin
                retired_count_d = retired_count_q + 1'b1;
            end
            // The pause request is honoured on the way into the next FETCH.
            state_d = run ? S_FETCH : S_IDLE;
            if (pc_q == LAST_PC) begin
                pc_d = '0;
                if (HALT_ON_WRAP != 0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q         <= S_IDLE;
            pc_q            <= '0;
            ir_q            <= '0;
            alu_op_q        <= OP_NOP;
            operand_q       <= '0;
            alu_en_q        <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            done_q          <= 1'b0;
            illegal_q       <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ir_q            <= ir_d;
            alu_op_q        <= alu_op_d;
            operand_q       <= operand_d;
            alu_en_q        <= alu_en_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            done_q          <= done_d;
            illegal_q       <= illegal_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign instruction_address = pc_q;
    assign alu_op              = alu_op_q;
    assign operand             = operand_q;
    assign alu_en              = alu_en_q;
    assign mem_req             = mem_req_q;
    assign mem_we              = mem_we_q;
    assign busy                = (state_q != S_IDLE);
    assign done                = done_q;
    assign illegal             = illegal_q;
    assign retired_count       = retired_count_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer. A scoreboard queue holds the
// expected ALU / memory / done events in program order; a negedge monitor
// pops and compares them as the DUT produces them. A second instance runs
// with HALT_ON_WRAP=0.
module tb_program_sequencer;
    import cpu_pkg::*;

    localparam logic [1:0] K_ALU  = 2'd1;
    localparam logic [1:0] K_MEM  = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    logic clk;
    logic rst, run, mem_ack;
    logic rst2, run2;

    logic [4:0]  addr1, addr2;
    logic [15:0] instr1, instr2;
    logic [3:0]  alu_op1, alu_op2;
    logic [11:0] operand1, operand2;
    logic        alu_en1, alu_en2, mem_req1, mem_req2, mem_we1, mem_we2;
    logic        busy1, busy2, done1, done2, illegal1, illegal2;
    logic [15:0] count1, count2;

    logic [15:0] rom1 [32];
    logic [15:0] rom2 [32];
    assign instr1 = rom1[addr1];
    assign instr2 = rom2[addr2];

    int tests_run = 0;
    int tests_failed = 0;

    logic [19:0] exp_q[$];
    int          cyc = 0;
    int          alu_cnt = 0;
    int          done_cnt = 0;
    bit          gap_chk_en = 0;
    bit          last_alu_valid = 0;
    int          last_alu_cyc = 0;
    logic [4:0]  last_alu_pc = '0;
    logic        mem_req_prev = 1'b0;

    program_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
`ifdef PROGRAM_SEQUENCER_STEP_EN
        .step(1'b1),
`endif
        .instruction_address(addr1), .instruction(instr1),
        .alu_op(alu_op1), .operand(operand1), .alu_en(alu_en1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_ack(mem_ack),
        .busy(busy1), .done(done1), .illegal(illegal1), .retired_count(count1)
    );

    program_sequencer #(.HALT_ON_WRAP(0)) dut_wrap (
        .clk(clk), .rst(rst2), .run(run2),
`ifdef PROGRAM_SEQUENCER_STEP_EN
        .step(1'b1),
`endif
        .instruction_address(addr2), .instruction(instr2),
        .alu_op(alu_op2), .operand(operand2), .alu_en(alu_en2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_ack(1'b0),
        .busy(busy2), .done(done2), .illegal(illegal2), .retired_count(count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] opnd);
        return {opnd, op};
    endfunction

    function automatic logic [19:0] ev(input logic [1:0] kind, input logic [4:0] pc,
                                       input logic [11:0] opnd, input logic we);
        return {kind, pc, opnd, we};
    endfunction

    // Scoreboard monitor: every strobe / new request / done pulse must match the queue head.
    always @(negedge clk) begin
        logic [19:0] got;
        bit          seen;
        seen = 0;
        got  = '0;
        if (alu_en1) begin
            got  = ev(K_ALU, addr1, operand1, 1'b0);
            seen = 1;
            alu_cnt++;
            if (gap_chk_en && last_alu_valid && addr1 == last_alu_pc + 5'd1)
                check("alu_gap", cyc - last_alu_cyc, 3);
            last_alu_valid = 1;
            last_alu_cyc   = cyc;
            last_alu_pc    = addr1;
        end else if (mem_req1 && !mem_req_prev) begin
            got  = ev(K_MEM, addr1, operand1, mem_we1);
            seen = 1;
        end else if (done1) begin
            got  = ev(K_DONE, addr1, 12'h000, 1'b0);
            seen = 1;
            done_cnt++;
        end
        if (seen) begin
            if (exp_q.size() == 0) check("sb_extra_event", {12'h0, got}, 32'h0);
            else check("sb_event", {12'h0, got}, {12'h0, exp_q.pop_front()});
        end
        mem_req_prev = mem_req1;
    end

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 32; i++) rom1[i] = ins(4'b1111, 12'h000);
    endtask

    initial begin
        rst2 = 1'b1; run2 = 1'b0;
        fill_nop();
        for (int i = 0; i < 32; i++) rom2[i] = ins(4'b0000, 12'(i));

        // ---------------- reset state ----------------
        do_reset();
        check("rst_addr", addr1, 0);
        check("rst_alu_op", alu_op1, 4'b1111);
        check("rst_operand", operand1, 0);
        check("rst_alu_en", alu_en1, 0);
        check("rst_mem_req", mem_req1, 0);
        check("rst_mem_we", mem_we1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_illegal", illegal1, 0);
        check("rst_count", count1, 0);

        // ---------------- full program, ack tied high ----------------
        fill_nop();
        for (int i = 1; i <= 9; i++) begin
            rom1[i] = ins(4'b0000, 12'(i * 3));
            exp_q.push_back(ev(K_ALU, 5'(i), 12'(i * 3), 1'b0));
        end
        rom1[10] = ins(4'b0111, 12'hA5A);
        rom1[11] = ins(4'b0110, 12'h3C3);
        exp_q.push_back(ev(K_MEM, 5'd10, 12'hA5A, 1'b1));
        exp_q.push_back(ev(K_MEM, 5'd11, 12'h3C3, 1'b0));
        exp_q.push_back(ev(K_DONE, 5'd0, 12'h000, 1'b0));
        alu_cnt = 0; done_cnt = 0; gap_chk_en = 1; last_alu_valid = 0;
        mem_ack = 1'b1; run = 1'b1;
        begin
            int n = 0;
            while (!done1 && n < 400) begin @(negedge clk); n++; end
            check("prog_done_seen", done1, 1);
            check("prog_done_busy", busy1, 0);
            check("prog_done_pc", addr1, 0);
            check("prog_count", count1, 32);
            run = 1'b0;
        end
        repeat (4) @(negedge clk);
        gap_chk_en = 0;
        check("prog_alu_pulses", alu_cnt, 9);
        check("prog_done_once", done_cnt, 1);
        check("prog_sb_empty", exp_q.size(), 0);
        check("prog_idle", busy1, 0);

        // ---------------- STORE with delayed ack ----------------
        do_reset();
        fill_nop();
        rom1[10] = ins(4'b0111, 12'h5A5);
        exp_q.push_back(ev(K_MEM, 5'd10, 12'h5A5, 1'b1));
        run = 1'b1;
        begin
            int n = 0;
            while (!mem_req1 && n < 200) begin @(negedge clk); n++; end
            check("st_req_seen", mem_req1, 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("st_hold_req", mem_req1, 1);
            check("st_hold_we", mem_we1, 1);
            check("st_hold_operand", operand1, 12'h5A5);
            check("st_hold_alu_op", alu_op1, 4'b0111);
            check("st_hold_pc", addr1, 10);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("st_ack_req", mem_req1, 0);
        check("st_ack_pc", addr1, 11);
        check("st_ack_count", count1, 11);
        check("st_sb_empty", exp_q.size(), 0);

        // ---------------- undefined opcode ----------------
        do_reset();
        fill_nop();
        rom1[2] = ins(4'b1010, 12'h777);
        run = 1'b1;
        begin
            int n = 0;
            while (!illegal1 && n < 100) begin
                @(negedge clk); n++;
                if (!illegal1) check("ill_early", addr1 <= 5'd2, 1);
            end
            check("ill_seen", illegal1, 1);
            check("ill_pc", addr1, 3);
            check("ill_alu_op", alu_op1, 4'b1010);
            check("ill_count", count1, 3);
        end
        repeat (6) @(negedge clk);
        check("ill_sticky", illegal1, 1);
        check("ill_sb_empty", exp_q.size(), 0);

        // ---------------- reset during MEM ----------------
        do_reset();
        fill_nop();
        rom1[0] = ins(4'b1100, 12'h000);
        rom1[1] = ins(4'b0111, 12'h0F0);
        exp_q.push_back(ev(K_MEM, 5'd1, 12'h0F0, 1'b1));
        run = 1'b1;
        begin
            int n = 0;
            while (!mem_req1 && n < 100) begin @(negedge clk); n++; end
            check("rm_req_seen", mem_req1, 1);
            check("rm_illegal_pre", illegal1, 1);
        end
        run = 1'b0; rst = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        check("rm_mem_req", mem_req1, 0);
        check("rm_mem_we", mem_we1, 0);
        check("rm_pc", addr1, 0);
        check("rm_busy", busy1, 0);
        check("rm_count", count1, 0);
        check("rm_illegal", illegal1, 0);
        check("rm_alu_op", alu_op1, 4'b1111);
        rst = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rm_stays_idle", busy1, 0);
        check("rm_sb_empty", exp_q.size(), 0);

        // ---------------- pause during EXEC and resume ----------------
        do_reset();
        fill_nop();
        rom1[4] = ins(4'b0001, 12'h044);
        rom1[5] = ins(4'b0010, 12'h055);
        exp_q.push_back(ev(K_ALU, 5'd4, 12'h044, 1'b0));
        exp_q.push_back(ev(K_ALU, 5'd5, 12'h055, 1'b0));
        run = 1'b1;
        begin
            int n = 0;
            while (!alu_en1 && n < 100) begin @(negedge clk); n++; end
            check("pz_exec_seen", alu_en1, 1);
            check("pz_exec_pc", addr1, 4);
            run = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("pz_busy", busy1, 0);
        check("pz_pc", addr1, 5);
        check("pz_count", count1, 5);
        run = 1'b1;
        begin
            int n = 0;
            while (!alu_en1 && n < 100) begin @(negedge clk); n++; end
            check("pz_resume_seen", alu_en1, 1);
            check("pz_resume_pc", addr1, 5);
            check("pz_resume_alu_op", alu_op1, 4'b0010);
            run = 1'b0;
        end
        @(negedge clk);
        check("pz_sb_empty", exp_q.size(), 0);

        // ---------------- HALT_ON_WRAP = 0 ----------------
        rst2 = 1'b0; run2 = 1'b1;
        begin
            int n = 0;
            int a = 0;
            bit ds = 0;
            while (count2 != 16'd32 && n < 300) begin
                @(negedge clk); n++;
                if (alu_en2) a++;
                if (done2) ds = 1;
            end
            check("wr_count", count2, 32);
            check("wr_pc", addr2, 0);
            check("wr_busy", busy2, 1);
            check("wr_alu_pulses", a, 32);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done2) ds = 1;
            end
            check("wr_no_done", ds, 0);
            check("wr_busy_cont", busy2, 1);
            check("wr_count_cont", count2, 34);
            check("wr_pc_cont", addr2, 2);
            check("wr_illegal", illegal2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
